// File: rtl/display_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : display_pkg                                                    |
// | Brief    : Shared types, constants and helpers for the 7-segment scan     |
// |            controller and its BCD decoder.                                |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
package display_pkg;

  // Two-phase scan: anodes dark (GUARD) or one digit lit (SHOW)
  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // All segments off (active-low bus)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Out-of-range BCD code the decoder renders as blank
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : decodificadorBCD7segmentos                                     |
// | Brief    : BCD to active-low 7-segment decoder, {g,f,e,d,c,b,a}.          |
// |            Codes A..F render blank.                                       |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module decodificadorBCD7segmentos
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  // Pure lookup; non-decimal codes fall through to blank
  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_bcd)
      4'h0:    o_seg_n = 7'b1000000;
      4'h1:    o_seg_n = 7'b1111001;
      4'h2:    o_seg_n = 7'b0100100;
      4'h3:    o_seg_n = 7'b0110000;
      4'h4:    o_seg_n = 7'b0011001;
      4'h5:    o_seg_n = 7'b0010010;
      4'h6:    o_seg_n = 7'b0000010;
      4'h7:    o_seg_n = 7'b1111000;
      4'h8:    o_seg_n = 7'b0000000;
      4'h9:    o_seg_n = 7'b0010000;
      default: o_seg_n = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : display_scan_controller                                        |
// | Brief    : Time-multiplexed scan of N_DIGITS common-segment displays      |
// |            through one shared decoder, with dwell/guard sequencing,       |
// |            frame-coherent loading, leading-zero blanking and DPs.         |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module display_scan_controller
  import display_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DWELL_CYC  = 12500,
  parameter int GUARD_CYC  = 16,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*N_DIGITS-1:0]         bcd_in,
  input  logic [N_DIGITS-1:0]           dp_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic [N_DIGITS-1:0]           an,
  output logic [clog2(N_DIGITS)-1:0]    digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W   = clog2(N_DIGITS);
  localparam int CNT_MAX = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]    c_dwell_last = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0]    c_guard_last = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0]    c_idx_last   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] c_an_off     = {N_DIGITS{AN_ACT_LOW}};

  scan_state_e             r_state;
  scan_state_e             w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_wrap;

  logic [4*N_DIGITS-1:0]   r_pend_bcd;
  logic [N_DIGITS-1:0]     r_pend_dp;
  logic [4*N_DIGITS-1:0]   r_act_bcd;
  logic [N_DIGITS-1:0]     r_act_dp;
  logic [4*N_DIGITS-1:0]   w_act_bcd_nxt;
  logic [N_DIGITS-1:0]     w_act_dp_nxt;

  logic [N_DIGITS-1:0]     w_nz;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic [N_DIGITS-1:0]     w_an_hot;
  logic                    w_force_blank;
  logic [3:0]              w_dec_in;
  logic [6:0]              w_dec_seg;

  logic [6:0]              r_seg_n;
  logic                    r_dp_n;
  logic [N_DIGITS-1:0]     r_an;
  logic                    r_frame_done;

  // Next-state logic: count the phase, flip phase at terminal count, advance digit after SHOW
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    case (r_state)
      GUARD: begin
        if (r_cnt == c_guard_last) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == c_dwell_last) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = '0;
          if (r_idx == c_idx_last) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = GUARD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Active data only changes on the wrap edge, so a frame is never torn;
  // a load on that same edge lands in pending and waits a full frame
  assign w_act_bcd_nxt = w_wrap ? r_pend_bcd : r_act_bcd;
  assign w_act_dp_nxt  = w_wrap ? r_pend_dp  : r_act_dp;

  // Nonzero OR-chain from the most significant digit downward:
  // w_nz[k] is set if any of digits k..N-1 is nonzero
  always_comb begin
    w_nz = '0;
    w_nz[N_DIGITS-1] = |w_act_bcd_nxt[4*(N_DIGITS-1) +: 4];
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      w_nz[k] = w_nz[k+1] | (|w_act_bcd_nxt[4*k +: 4]);
    end
  end

  // Select the nibble/DP of the digit about to be shown and its one-hot anode
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_an_hot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nib       = w_act_bcd_nxt[4*k +: 4];
        w_dp_sel    = w_act_dp_nxt[k];
        w_an_hot[k] = 1'b1;
      end
    end
  end

  // Digit 0 is never blanked so an all-zero value still reads "0"
  assign w_force_blank = blank_lz && (w_idx_nxt != '0) && !w_nz[w_idx_nxt];
  assign w_dec_in      = w_force_blank ? BCD_BLANK : w_nib;

  decodificadorBCD7segmentos u_dec (
    .i_bcd   (w_dec_in),
    .o_seg_n (w_dec_seg)
  );

  // Scan FSM, phase counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Pending (last load wins) and active display data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_bcd <= '0;
      r_pend_dp  <= '0;
      r_act_bcd  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (load) begin
        r_pend_bcd <= bcd_in;
        r_pend_dp  <= dp_in;
      end
      r_act_bcd <= w_act_bcd_nxt;
      r_act_dp  <= w_act_dp_nxt;
    end
  end

  // Output registers built from next-state values so segments and anodes switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= c_an_off;
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_state_nxt == SHOW) begin
        r_an    <= w_an_hot ^ c_an_off;
        r_seg_n <= w_dec_seg;
        r_dp_n  <= ~w_dp_sel;
      end else begin
        r_an    <= c_an_off;
        r_seg_n <= SEG_BLANK;
        r_dp_n  <= 1'b1;
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an         = r_an;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_display_scan_controller                                     |
// | Brief    : Scoreboard bench for display_scan_controller (4 digits,        |
// |            dwell 4, guard 2, active-low anodes).                          |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int N = 4;
  localparam int D = 4;
  localparam int G = 2;
  localparam int P = N * (D + G);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  exp_t q[$];

  // Reference model state: edges since reset and frame-level data
  int          m_t = 0;
  int          m_d = 0;
  bit          m_lit = 1'b0;
  logic [15:0] m_pend_bcd = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [15:0] m_act_bcd = '0;
  logic [3:0]  m_act_dp = '0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  display_scan_controller #(
    .N_DIGITS   (N),
    .DWELL_CYC  (D),
    .GUARD_CYC  (G),
    .AN_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected segment pattern for digit d of a 4-digit value
  function automatic logic [6:0] exp_seg(input logic [15:0] act, input int d, input logic lz);
    logic [15:0] up;
    logic [3:0]  nib;
    up  = act >> (4 * d);
    nib = up[3:0];
    if (lz && d >= 1 && up == 16'h0) return 7'h7F;
    if (nib > 4'd9) return 7'h7F;
    return seg_tab[nib];
  endfunction

  // Model: position in frame derived from edge count since reset
  initial begin
    exp_t e;
    int   s;
    int   ph;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_d = 0; m_lit = 1'b0;
        m_pend_bcd = '0; m_pend_dp = '0;
        m_act_bcd = '0;  m_act_dp = '0;
      end else begin
        m_t = m_t + 1;
        s   = m_t % P;
        m_d = s / (D + G);
        ph  = s % (D + G);
        if (s == 0) begin
          m_act_bcd = m_pend_bcd;
          m_act_dp  = m_pend_dp;
        end
        if (load) begin
          m_pend_bcd = bcd_in;
          m_pend_dp  = dp_in;
        end
        m_lit = (ph >= G);
        e.idx = 2'(m_d);
        e.fd  = (s == 0);
        if (m_lit) begin
          e.an  = ~(4'b0001 << m_d);
          e.seg = exp_seg(m_act_bcd, m_d, blank_lz);
          e.dp  = ~m_act_dp[m_d];
        end else begin
          e.an  = 4'hF;
          e.seg = 7'h7F;
          e.dp  = 1'b1;
        end
        if (m_lit || e.fd) q.push_back(e);
      end
    end
  end

  // Monitor: pop on every lit digit or frame pulse; dark cycles must be blank with nothing owed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (an != 4'hF || frame_done) begin
          n_chk++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output an=%b seg=%b dp=%b idx=%0d fd=%b, none expected",
                     an, seg_n, dp_n, digit_idx, frame_done);
          end else begin
            e = q.pop_front();
            if (an !== e.an || seg_n !== e.seg || dp_n !== e.dp ||
                digit_idx !== e.idx || frame_done !== e.fd) begin
              n_err++;
              $display("FAIL scan_output t=%0d an=%b/%b seg=%b/%b dp=%b/%b idx=%0d/%0d fd=%b/%b (got/exp)",
                       m_t, an, e.an, seg_n, e.seg, dp_n, e.dp, digit_idx, e.idx, frame_done, e.fd);
            end
          end
        end else begin
          n_chk++;
          if (seg_n !== 7'h7F || dp_n !== 1'b1 || q.size() != 0) begin
            n_err++;
            $display("FAIL guard_dark seg=%b dp=%b owed=%0d, exp seg=1111111 dp=1 owed=0",
                     seg_n, dp_n, q.size());
            q.delete();
          end
        end
      end
    end
  end

  task automatic check_reset(input string name);
    n_chk++;
    if (an !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s an=%b seg=%b dp=%b idx=%0d fd=%b, exp an=1111 seg=1111111 dp=1 idx=0 fd=0",
               name, an, seg_n, dp_n, digit_idx, frame_done);
    end
  endtask

  // Apply inputs for exactly one rising edge; called and returns at a falling edge
  task automatic step(input logic [15:0] b, input logic [3:0] d, input logic ld, input logic lz);
    bcd_in   = b;
    dp_in    = d;
    load     = ld;
    blank_lz = lz;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic lz);
    repeat (n) step(bcd_in, dp_in, 1'b0, lz);
  endtask

  task automatic wait_lit(input int k);
    int i;
    i = 0;
    while (!(m_lit && m_d == k) && i < 100) begin
      idle(1, blank_lz);
      i++;
    end
    if (!(m_lit && m_d == k)) begin
      n_chk++; n_err++;
      $display("FAIL wait_digit_%0d timeout after %0d cycles", k, i);
    end
  endtask

  task automatic wait_wrap_next();
    int i;
    i = 0;
    while (((m_t + 1) % P) != 0 && i < 100) begin
      idle(1, blank_lz);
      i++;
    end
    if (((m_t + 1) % P) != 0) begin
      n_chk++; n_err++;
      $display("FAIL wait_wrap timeout after %0d cycles", i);
    end
  endtask

  initial begin
    logic [15:0] rb;
    logic        lz;
    rst_n = 1'b1; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async_entry");
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;

    // Load right after release; first frame still shows the reset data
    step(16'h1234, 4'b0000, 1'b1, 1'b0);
    idle(3 * P, 1'b0);

    // Leading-zero blanking on, then off
    step(16'h0070, 4'b0000, 1'b1, 1'b1);
    idle(2 * P, 1'b1);
    idle(P, 1'b0);

    // Mid-frame load while digit 1 is lit
    wait_lit(1);
    step(16'h9999, 4'b0000, 1'b1, 1'b0);
    idle(2 * P, 1'b0);

    // Load coinciding with the wrap edge
    wait_wrap_next();
    step(16'h4321, 4'b0000, 1'b1, 1'b0);
    idle(3 * P, 1'b0);

    // Non-decimal nibble with a decimal point on the same digit
    step(16'h1C34, 4'b0100, 1'b1, 1'b0);
    idle(2 * P, 1'b0);

    // Randomized loads, values biased toward zeros, random blanking level
    lz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        rb[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) lz = ~lz;
      step(rb, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), lz);
    end

    // Async reset in the middle of digit 2's SHOW phase
    step(16'h5678, 4'b1111, 1'b1, 1'b0);
    idle(2 * P, 1'b0);
    wait_lit(2);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_show");
    repeat (2) @(negedge clk);
    check_reset("reset_mid_hold");
    rst_n = 1'b1;
    idle(2 * P, 1'b0);

    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL outputs_owed %0d outstanding, exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
